param_universal_shift_register: RTL and testbench
=================================================

Name: param_universal_shift_register

Overview:
- WIDTH-bit universal shift register with 8 operating modes: hold, shift, rotate, arithmetic shift, parallel load and clear.
- Adds an autonomous burst engine that repeats a shift or rotate operation a programmed number of cycles, with busy/done handshake.
- Next-generation building block for serialisers, barrel-shift emulation and datapath scratch registers in the sequential-design library.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2.
- AMT_W, 4, width of the burst amount field; max burst length = 2^AMT_W - 1.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous reset, active-high
- en  input  1  single-step enable; ignored while busy
- mode  input  3  operation select (encoding below)
- par_in  input  WIDTH  parallel load data
- msb_in  input  1  serial input entering at q[WIDTH-1] on SHR
- lsb_in  input  1  serial input entering at q[0] on SHL
- start  input  1  burst request, sampled at the clock edge
- amount  input  AMT_W  burst length in operations
- q  output  WIDTH  register contents
- msb_out  output  1  equals q[WIDTH-1], combinational from the register
- lsb_out  output  1  equals q[0], combinational from the register
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse at burst completion

Behaviour:
- All state updates occur on the rising edge of clk.
- rst has highest priority. On reset: q=0, busy=0, done=0, internal counter=0, FSM=IDLE.
- Mode encoding:
  - 000 HOLD: q unchanged.
  - 001 SHR: q <= {msb_in, q[W-1:1]}.
  - 010 SHL: q <= {q[W-2:0], lsb_in}.
  - 011 LOAD: q <= par_in.
  - 100 ROR: q <= {q[0], q[W-1:1]}.
  - 101 ROL: q <= {q[W-2:0], q[W-1]}.
  - 110 ASR: q <= {q[W-1], q[W-1:1]}.
  - 111 CLR: q <= 0.
- Burst-capable modes are SHR, SHL, ROR, ROL and ASR.
- FSM states: IDLE and BURST.
- IDLE, start=1 with a burst-capable mode and amount>0:
  - Latch mode into op_r and amount into rem.
  - Set busy=1 and go to BURST.
  - q is not modified on this edge.
- IDLE, start=1 with a burst-capable mode and amount=0:
  - Stay in IDLE; q unchanged.
  - Set done=1 for the next cycle.
- IDLE, start=1 with a non-burst mode (HOLD/LOAD/CLR): start is ignored and the normal en behaviour applies.
- IDLE, otherwise: if en=1, apply mode once; if en=0, hold q.
- BURST, each edge:
  - Apply op_r to q and decrement rem.
  - en, mode, start, par_in and amount are ignored.
  - msb_in and lsb_in are sampled live each cycle.
- BURST, edge where rem==1: after that edge busy=0, done=1, FSM=IDLE.
- Burst timing: busy is high for exactly `amount` cycles. The final q value is visible in the same cycle that done is high.
- done is high for exactly one cycle; otherwise done=0.
- A new start may be accepted in the cycle done is high, because the FSM is already IDLE.
- amount may exceed WIDTH. Shifts saturate naturally (SHR/SHL fill with serial input, ASR fills with sign). Rotates wrap, so ROR by WIDTH returns the original value.
- rst asserted during BURST aborts the burst: q=0, busy=0, and no done pulse is generated.
- Outputs q, busy and done are registered. msb_out and lsb_out are direct bit selects of q.

Test Plan:
- Load/hold: rst 1 cycle, then LOAD 0xA5 with en=1 → q=0xA5 next cycle. Then SHR with en=0 for 3 cycles → q stays 0xA5. msb_out=1, lsb_out=1.
- Single steps from 0xA5:
  - SHR, msb_in=1 → 0xD2.
  - Then SHL, lsb_in=0 → 0xA4.
  - LOAD 0x80, then ASR → 0xC0.
  - ROR from 0x01 → 0x80.
  - CLR → 0x00.
- Burst ROL, amount=3, from 0x81:
  - busy high exactly 3 cycles; q steps 0x03, 0x06, 0x0C.
  - done pulses 1 cycle with q=0x0C.
  - Toggling en/mode/start during the burst has no effect.
- Edge amounts:
  - start with amount=0 → busy stays 0, done pulses next cycle, q unchanged.
  - ROR amount=8 from 0x3C → ends at 0x3C.
  - ROR amount=9 from 0x3C → ends at 0x1E.
- Reset mid-burst: SHL amount=6 from 0xFF with lsb_in=0; assert rst after 2 burst cycles → q=0x00, busy=0, no done pulse. A new start is accepted the cycle after rst deasserts.
- Back-to-back bursts: start a second SHR (amount=2, msb_in=1) in the cycle done is high → busy rises on that edge and the second burst completes correctly.

Source files
------------

// File: rtl/param_universal_shift_register.sv
// WIDTH-bit universal shift register with eight single-step modes and a
// burst engine that repeats a shift/rotate a programmed number of cycles.
module param_universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             msb_in,
  input  logic             lsb_in,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             msb_out,
  output logic             lsb_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  localparam logic [AMT_W-1:0] AMT_ZERO = {AMT_W{1'b0}};
  localparam logic [AMT_W-1:0] AMT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] par,
    input logic             mi,
    input logic             li
  );
    logic [WIDTH-1:0] res;
    case (op)
      MODE_HOLD: res = cur;
      MODE_SHR:  res = {mi, cur[WIDTH-1:1]};
      MODE_SHL:  res = {cur[WIDTH-2:0], li};
      MODE_LOAD: res = par;
      MODE_ROR:  res = {cur[0], cur[WIDTH-1:1]};
      MODE_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      MODE_CLR:  res = {WIDTH{1'b0}};
      default:   res = cur;
    endcase
    return res;
  endfunction

  function automatic logic is_burst_mode(input logic [2:0] op);
    logic res;
    case (op)
      MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR: res = 1'b1;
      default:                                          res = 1'b0;
    endcase
    return res;
  endfunction

  // Next-state, datapath and handshake computation.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    op_d    = op_q;
    rem_d   = rem_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && is_burst_mode(mode)) begin
          // The accepting edge only arms the engine; q moves from the next edge on.
          if (amount != AMT_ZERO) begin
            op_d    = mode;
            rem_d   = amount;
            state_d = ST_BURST;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else if (en) begin
          q_d = apply_op(mode, q_q, par_in, msb_in, lsb_in);
        end else begin
          q_d = q_q;
        end
      end
      ST_BURST: begin
        q_d   = apply_op(op_q, q_q, par_in, msb_in, lsb_in);
        rem_d = rem_q - AMT_ONE;
        if (rem_q == AMT_ONE) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      q_q     <= {WIDTH{1'b0}};
      op_q    <= MODE_HOLD;
      rem_q   <= AMT_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q       = q_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign msb_out = q_q[WIDTH-1];
  assign lsb_out = q_q[0];

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Directed bench for param_universal_shift_register: expectations are queued
// when stimulus is applied and compared after the following clock edge.
module tb_param_universal_shift_register;

  localparam int WIDTH = 8;
  localparam int AMT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] par_in;
  logic             msb_in;
  logic             lsb_in;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic             msb_out;
  logic             lsb_out;
  logic             busy;
  logic             done;

  param_universal_shift_register #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .par_in(par_in),
    .msb_in(msb_in), .lsb_in(lsb_in), .start(start), .amount(amount),
    .q(q), .msb_out(msb_out), .lsb_out(lsb_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [WIDTH-1:0] ror_seq [8] = '{8'h1E, 8'h0F, 8'h87, 8'hC3, 8'hE1, 8'hF0, 8'h78, 8'h3C};

  // Queue the expectation for the inputs just driven, clock once, then compare.
  task automatic step(input string tag, input logic [WIDTH-1:0] eq, input logic eb, input logic ed);
    exp_t e;
    e.tag = tag; e.q = eq; e.busy = eb; e.done = ed;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert ({q, busy, done} === {e.q, e.busy, e.done}) else begin
      errors++;
      $error("FAIL %s: got q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
             e.tag, q, busy, done, e.q, e.busy, e.done);
    end
  endtask

  task automatic check_bits(input string tag, input logic em, input logic el);
    checks++;
    assert ({msb_out, lsb_out} === {em, el}) else begin
      errors++;
      $error("FAIL %s: got msb_out=%b lsb_out=%b, expected msb_out=%b lsb_out=%b",
             tag, msb_out, lsb_out, em, el);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'b000; par_in = 8'h00; msb_in = 1'b0;
    lsb_in = 1'b0; start = 1'b0; amount = 4'd0;
    step("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // Load and hold
    en = 1'b1; mode = 3'b011; par_in = 8'hA5;
    step("load_a5", 8'hA5, 1'b0, 1'b0);
    check_bits("bits_a5", 1'b1, 1'b1);
    en = 1'b0; mode = 3'b001;
    for (int i = 0; i < 3; i++) step("hold_en0", 8'hA5, 1'b0, 1'b0);

    // Single steps
    en = 1'b1; mode = 3'b001; msb_in = 1'b1;
    step("shr", 8'hD2, 1'b0, 1'b0);
    mode = 3'b010; lsb_in = 1'b0;
    step("shl", 8'hA4, 1'b0, 1'b0);
    mode = 3'b011; par_in = 8'h80;
    step("load_80", 8'h80, 1'b0, 1'b0);
    mode = 3'b110;
    step("asr", 8'hC0, 1'b0, 1'b0);
    mode = 3'b011; par_in = 8'h01;
    step("load_01", 8'h01, 1'b0, 1'b0);
    mode = 3'b100;
    step("ror", 8'h80, 1'b0, 1'b0);
    check_bits("bits_80", 1'b1, 1'b0);
    mode = 3'b111;
    step("clr", 8'h00, 1'b0, 1'b0);

    // Burst ROL x3 from 0x81 with distracting inputs during the burst
    mode = 3'b011; par_in = 8'h81;
    step("load_81", 8'h81, 1'b0, 1'b0);
    en = 1'b0; mode = 3'b101; start = 1'b1; amount = 4'd3;
    step("rol_accept", 8'h81, 1'b1, 1'b0);
    en = 1'b1; mode = 3'b011; par_in = 8'hFF; amount = 4'd5;
    step("rol_b1", 8'h03, 1'b1, 1'b0);
    mode = 3'b111; start = 1'b0;
    step("rol_b2", 8'h06, 1'b1, 1'b0);
    en = 1'b0; start = 1'b1;
    step("rol_b3_done", 8'h0C, 1'b0, 1'b1);
    start = 1'b0; mode = 3'b000;
    step("rol_after", 8'h0C, 1'b0, 1'b0);

    // Zero amount: done pulse only
    en = 1'b1; mode = 3'b001; start = 1'b1; amount = 4'd0;
    step("amt0", 8'h0C, 1'b0, 1'b1);
    en = 1'b0; start = 1'b0;
    step("amt0_after", 8'h0C, 1'b0, 1'b0);

    // ROR by WIDTH wraps back to the original value
    en = 1'b1; mode = 3'b011; par_in = 8'h3C;
    step("load_3c", 8'h3C, 1'b0, 1'b0);
    en = 1'b0; mode = 3'b100; start = 1'b1; amount = 4'd8;
    step("ror8_accept", 8'h3C, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 8; i++) step("ror8", ror_seq[i], (i < 7), (i == 7));

    // ROR by WIDTH+1, started in the done cycle of the previous burst
    start = 1'b1; amount = 4'd9;
    step("ror9_accept", 8'h3C, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 9; i++) step("ror9", ror_seq[i % 8], (i < 8), (i == 8));
    step("ror9_after", 8'h1E, 1'b0, 1'b0);

    // Reset during a burst aborts with no done pulse
    en = 1'b1; mode = 3'b011; par_in = 8'hFF;
    step("load_ff", 8'hFF, 1'b0, 1'b0);
    en = 1'b0; mode = 3'b010; lsb_in = 1'b0; start = 1'b1; amount = 4'd6;
    step("shl6_accept", 8'hFF, 1'b1, 1'b0);
    start = 1'b0;
    step("shl6_b1", 8'hFE, 1'b1, 1'b0);
    step("shl6_b2", 8'hFC, 1'b1, 1'b0);
    rst = 1'b1;
    step("abort_rst", 8'h00, 1'b0, 1'b0);
    rst = 1'b0; mode = 3'b010; lsb_in = 1'b1; start = 1'b1; amount = 4'd1;
    step("post_rst_accept", 8'h00, 1'b1, 1'b0);
    start = 1'b0;
    step("shl1_done", 8'h01, 1'b0, 1'b1);

    // Back-to-back: second burst accepted in the done cycle
    mode = 3'b001; msb_in = 1'b1; start = 1'b1; amount = 4'd2;
    step("b2b_accept", 8'h01, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000;
    step("b2b_b1", 8'h80, 1'b1, 1'b0);
    step("b2b_done", 8'hC0, 1'b0, 1'b1);
    step("b2b_after", 8'hC0, 1'b0, 1'b0);
    check_bits("bits_c0", 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
